seq_divider: RTL and testbench

//  Sequential unsigned restoring divider; the inverse companion of the AND/full-adder array multiplier.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider_div_step.sv | 41 ++++
 rtl/seq_divider.sv | 101 ++++++++++
 tb/tb_seq_divider.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings,
// default width and the full-adder cell used by the borrow-ripple subtractor.
package seq_divider_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Full-adder cell: returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface seq_divider_if
    import seq_divider_pkg::*;
    #(parameter int unsigned WIDTH = WIDTH_DEF);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor with a full-adder borrow ripple, keep or restore.
module seq_divider_div_step
    import seq_divider_pkg::*;
    #(parameter int unsigned WIDTH = WIDTH_DEF)
(
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The restored remainder is always below the divisor, so only the
    // shifted trial value needs the extra top bit.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub_b;
    logic [WIDTH-1:0] diff;
    logic [1:0]       fa;
    logic             carry;

    assign shifted = {rem, dvd_bit};
    assign sub_b   = ~divisor;

    // Two's-complement subtract; final carry set means no borrow.
    always_comb begin
        carry = 1'b1;
        diff  = '0;
        fa    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            fa      = full_add(shifted[i], sub_b[i], carry);
            diff[i] = fa[0];
            carry   = fa[1];
        end
        // Top stage subtracts a zero divisor bit: carry-out reduces to a | cin
        q_bit = shifted[WIDTH] | carry;
    end

    assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and held quotient/remainder/div_by_zero results.
module seq_divider
    import seq_divider_pkg::*;
    #(parameter int unsigned WIDTH = WIDTH_DEF)
(
    input  logic        clk,
    input  logic        rst,
    seq_divider_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             accept_c;
    logic             last_step_c;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    seq_divider_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem_r),
        .dvd_bit  (dvd_r[WIDTH-1]),
        .divisor  (dsr_r),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Next-state logic; DONE accepts a new start just like IDLE
    always_comb begin
        state_nx    = state;
        accept_c    = 1'b0;
        last_step_c = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept_c = 1'b1;
                    state_nx = (bus.divisor == '0) ? ST_DONE : ST_CALC;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_step_c = 1'b1;
                    state_nx    = ST_DONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            dvd_r           <= '0;
            dsr_r           <= '0;
            rem_r           <= '0;
            quo_r           <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            state    <= state_nx;
            bus.busy <= (state == ST_CALC);
            bus.done <= (state == ST_DONE);
            if (accept_c) begin
                dvd_r <= bus.dividend;
                dsr_r <= bus.divisor;
                rem_r <= '0;
                quo_r <= '0;
                cnt   <= '0;
                if (bus.divisor == '0) begin
                    bus.quotient    <= '1;
                    bus.remainder   <= bus.dividend;
                    bus.div_by_zero <= 1'b1;
                end
            end else if (state == ST_CALC) begin
                rem_r <= step_rem;
                quo_r <= {quo_r[WIDTH-2:0], step_q};
                dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                cnt   <= cnt + CNT_W'(1);
                if (last_step_c) begin
                    bus.quotient    <= {quo_r[WIDTH-2:0], step_q};
                    bus.remainder   <= step_rem;
                    bus.div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model checked every cycle plus
// directed vectors with hand-computed results and latencies.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Reference model: outputs follow from the accept edge and plain / and %
    int           cyc = 0;
    bit           active = 0;
    bit           m_dbz = 0;
    int           a_edge = 0;
    int           f_edge = 0;
    logic [W-1:0] p_q, p_r;
    logic [W-1:0] e_q = '0;
    logic [W-1:0] e_r = '0;
    bit           e_dbz = 0, e_busy = 0, e_done = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            active = 0; e_q = '0; e_r = '0; e_dbz = 0; e_busy = 0; e_done = 0;
        end else begin
            e_busy = active && !m_dbz && cyc > a_edge && cyc <= f_edge;
            e_done = active && cyc == f_edge + 1;
            if (active && cyc == f_edge) begin
                e_q = p_q; e_r = p_r; e_dbz = m_dbz;
            end
            if (bus.start && (!active || cyc > f_edge)) begin
                active = 1;
                a_edge = cyc;
                m_dbz  = (bus.divisor == 0);
                if (m_dbz) begin
                    p_q = '1; p_r = bus.dividend; f_edge = cyc;
                    e_q = '1; e_r = bus.dividend; e_dbz = 1;
                end else begin
                    p_q    = bus.dividend / bus.divisor;
                    p_r    = bus.dividend % bus.divisor;
                    f_edge = cyc + W;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy", bus.busy, e_busy);
            check("done", bus.done, e_done);
            check("quotient", bus.quotient, e_q);
            check("remainder", bus.remainder, e_r);
            check("div_by_zero", bus.div_by_zero, e_dbz);
        end
    end

    // Pulse start for one cycle and wait (bounded) for done; lat counts edges after accept
    task automatic run(input logic [W-1:0] dd, input logic [W-1:0] ds,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = dd; bus.divisor = ds;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            if (bus.done) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
        q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
    endtask

    task automatic directed(input string name, input logic [W-1:0] dd, input logic [W-1:0] ds,
                            input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic ez, input int elat);
        logic [W-1:0] q, r;
        logic z;
        int lat;
        run(dd, ds, q, r, z, lat);
        check({name, " latency"}, 64'(lat), 64'(elat));
        check({name, " q"}, q, eq);
        check({name, " r"}, r, er);
        check({name, " dbz"}, z, ez);
    endtask

    initial begin
        logic [W-1:0] q, r, dd, ds;
        logic z;
        int lat, dones, seen_q, seen_r;

        rst = 1'b1;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset q", bus.quotient, 0);
        check("reset r", bus.remainder, 0);
        check("reset dbz", bus.div_by_zero, 0);
        rst = 1'b0;

        directed("100/7",   8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9);
        directed("255/1",   8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9);
        directed("5/9",     8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9);
        directed("0/3",     8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 9);
        directed("255/255", 8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9);
        directed("37/0",    8'd37,  8'd0,   8'd255, 8'd37, 1'b1, 1);
        directed("9/3",     8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 9);

        // start held with new operands while calculating is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(negedge clk);
        bus.dividend = 8'd50; bus.divisor = 8'd5;
        repeat (7) @(negedge clk);
        bus.start = 1'b0;
        dones = 0; seen_q = -1; seen_r = -1;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) begin
                dones++; seen_q = int'(bus.quotient); seen_r = int'(bus.remainder);
            end
        end
        check("held start done count", 64'(dones), 64'(1));
        check("held start q", 64'(seen_q), 64'(14));
        check("held start r", 64'(seen_r), 64'(2));

        // reset on the 4th calculation edge discards the run
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset busy", bus.busy, 0);
        check("mid reset done", bus.done, 0);
        check("mid reset q", bus.quotient, 0);
        check("mid reset r", bus.remainder, 0);
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("mid reset no done", 64'(dones), 64'(0));

        // back-to-back: new start during the DONE state of 100/7
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd13;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b first done", bus.done, 1);
        check("b2b first q", bus.quotient, 8'd14);
        check("b2b first r", bus.remainder, 8'd2);
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            if (bus.done) begin
                if (j > 0) begin
                    lat = j;
                    break;
                end
            end
            @(negedge clk);
        end
        check("b2b second latency", 64'(lat), 64'(9));
        check("b2b second q", bus.quotient, 8'd15);
        check("b2b second r", bus.remainder, 8'd5);

        // random operands: invariant and exact latency on every completion
        for (int i = 0; i < 1000; i++) begin
            dd = 8'($urandom_range(0, 255));
            ds = (i % 50 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
            run(dd, ds, q, r, z, lat);
            if (ds == 0) begin
                check("rand dbz latency", 64'(lat), 64'(1));
                check("rand dbz flag", z, 1);
            end else begin
                check("rand latency", 64'(lat), 64'(9));
                check("rand invariant", 64'(q) * 64'(ds) + 64'(r), 64'(dd));
                check("rand r<d", 64'(r < ds), 64'(1));
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
